// File: rtl/rf_pkg.sv
// Shared constants and types for the 32 x 32 general-purpose register file.
// Decode and writeback stages import this to agree on index and data widths.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Index of the architectural zero register; it never holds anything else.
    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: selects a register by index, with the zero
// register forced to read as 0 regardless of what the storage holds.
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               idx,
    output logic [DATA_W-1:0]               data
);
    import rf_pkg::*;

    always_comb begin
        data = regs[idx];
        if (idx == ADDR_W'(ZERO_REG)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32-entry register file: two zero-latency read ports, one clocked write port,
// no write-to-read bypass, asynchronous active-low clear of every entry.
module register_file #(
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [1:0]        RegWrite,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2
);
    import rf_pkg::*;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                            write_en;

    // Any nonzero enable code writes; writes aimed at the zero register are dropped.
    assign write_en = (RegWrite != 2'b00) && (WriteReg != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_read1 (
        .regs (regs),
        .idx  (Read1),
        .data (Data1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_read2 (
        .regs (regs),
        .idx  (Read2),
        .data (Data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// run, all compared against an array model of the architectural registers.
`timescale 1ns/100ps
module tb_register_file;
    import rf_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_idx_t  Read1, Read2, WriteReg;
    logic [1:0] RegWrite;
    reg_data_t WriteData, Data1, Data2;

    int checks = 0;
    int errors = 0;

    reg_data_t model [32];

    register_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Read1     (Read1),
        .Read2     (Read2),
        .WriteReg  (WriteReg),
        .RegWrite  (RegWrite),
        .WriteData (WriteData),
        .Data1     (Data1),
        .Data2     (Data2)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Drive one write cycle and apply the architectural rule to the model.
    task automatic do_write(input int idx, input reg_data_t data, input logic [1:0] we);
        @(negedge clk);
        WriteReg  = reg_idx_t'(idx);
        WriteData = data;
        RegWrite  = we;
        @(posedge clk);
        if (we != 2'b00 && idx != 0) model[idx] = data;
        #1;
        RegWrite = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RegWrite = 2'b00; WriteReg = '0; WriteData = '0;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            Read1 = reg_idx_t'(i);
            Read2 = reg_idx_t'(31 - i);
            #0.1;
            checks++;
            if (Data1 !== 32'h0 || Data2 !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_initial idx %0d: got %h/%h expected 0/0", i, Data1, Data2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        WriteReg = 5'd1; WriteData = 32'h55555555; RegWrite = 2'b01;
        Read1 = 5'd1; Read2 = 5'd0;
        @(posedge clk);
        model[1] = 32'h55555555;
        #1;
        RegWrite = 2'b00;
        checks++;
        if (Data1 !== 32'h55555555) begin
            errors++;
            $display("[TB] FAIL basic_data1: got %h expected %h", Data1, 32'h55555555);
        end
        checks++;
        if (Data2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL basic_data2: got %h expected %h", Data2, 32'h0);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; RegWrite = 2'b01;
        Read1 = 5'd0; Read2 = 5'd0;
        @(posedge clk);
        #1;
        RegWrite = 2'b00;
        checks++;
        if (Data1 !== 32'h0 || Data2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reg0_write: got %h/%h expected 0/0", Data1, Data2);
        end
    endtask

    task automatic test_no_bypass();
        @(negedge clk);
        Read2 = 5'd1; WriteReg = 5'd1; WriteData = 32'haaaaaaaa; RegWrite = 2'b01;
        #1;
        checks++;
        if (Data2 !== 32'h55555555) begin
            errors++;
            $display("[TB] FAIL no_bypass_before: got %h expected %h", Data2, 32'h55555555);
        end
        @(posedge clk);
        model[1] = 32'haaaaaaaa;
        #1;
        RegWrite = 2'b00;
        checks++;
        if (Data2 !== 32'haaaaaaaa) begin
            errors++;
            $display("[TB] FAIL no_bypass_after: got %h expected %h", Data2, 32'haaaaaaaa);
        end
    endtask

    task automatic test_write_disable();
        Read1 = 5'd5; Read2 = 5'd6;
        do_write(5, 32'h12345678, 2'b00);
        checks++;
        if (Data1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_disable_00: got %h expected %h", Data1, 32'h0);
        end
        do_write(5, 32'h12345678, 2'b10);
        checks++;
        if (Data1 !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL write_enable_10: got %h expected %h", Data1, 32'h12345678);
        end
        do_write(6, 32'h87654321, 2'b11);
        checks++;
        if (Data2 !== 32'h87654321) begin
            errors++;
            $display("[TB] FAIL write_enable_11: got %h expected %h", Data2, 32'h87654321);
        end
    endtask

    task automatic test_random();
        reg_data_t exp1, exp2;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            Read1     = reg_idx_t'($urandom_range(0, 31));
            Read2     = reg_idx_t'($urandom_range(0, 31));
            WriteReg  = reg_idx_t'($urandom_range(0, 31));
            WriteData = $urandom;
            RegWrite  = 2'($urandom_range(0, 3));
            #1;
            exp1 = model[Read1];
            exp2 = model[Read2];
            checks++;
            if (Data1 !== exp1 || Data2 !== exp2) begin
                errors++;
                $display("[TB] FAIL random_pre iter %0d: got %h/%h expected %h/%h", n, Data1, Data2, exp1, exp2);
            end
            @(posedge clk);
            if (RegWrite != 2'b00 && WriteReg != 5'd0) model[WriteReg] = WriteData;
            #1;
            exp1 = model[Read1];
            exp2 = model[Read2];
            checks++;
            if (Data1 !== exp1 || Data2 !== exp2) begin
                errors++;
                $display("[TB] FAIL random_post iter %0d: got %h/%h expected %h/%h", n, Data1, Data2, exp1, exp2);
            end
        end
        RegWrite = 2'b00;
    endtask

    task automatic test_full_sweep();
        reg_data_t exp1, exp2;
        for (int i = 1; i < 32; i++) begin
            do_write(i, 32'hA5A50000 + i, 2'($urandom_range(1, 3)));
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            Read1 = reg_idx_t'(i);
            Read2 = reg_idx_t'(31 - i);
            #1;
            exp1 = (i == 0) ? 32'h0 : 32'hA5A50000 + i;
            exp2 = (i == 31) ? 32'h0 : 32'hA5A50000 + (31 - i);
            checks++;
            if (Data1 !== exp1 || Data2 !== exp2) begin
                errors++;
                $display("[TB] FAIL sweep pair %0d/%0d: got %h/%h expected %h/%h", i, 31 - i, Data1, Data2, exp1, exp2);
            end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Read1 = reg_idx_t'(31 - i);
            Read2 = reg_idx_t'(i);
            #0.1;
            checks++;
            if (Data1 !== 32'h0 || Data2 !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_async idx %0d: got %h/%h expected 0/0", 31 - i, Data1, Data2);
            end
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        Read1 = 5'd7;
        do_write(7, 32'h0F0F1234, 2'b01);
        checks++;
        if (Data1 !== 32'h0F0F1234) begin
            errors++;
            $display("[TB] FAIL write_after_reset: got %h expected %h", Data1, 32'h0F0F1234);
        end
    endtask

    task automatic test_reset_mid_write();
        Read1 = 5'd9;
        do_write(9, 32'hCAFEF00D, 2'b01);
        @(negedge clk);
        WriteReg = 5'd9; WriteData = 32'h0BADBEEF; RegWrite = 2'b01;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_write_during: got %h expected %h", Data1, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        RegWrite = 2'b00;
        model_clear();
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_write_after: got %h expected %h", Data1, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reg0();
        test_no_bypass();
        test_write_disable();
        test_random();
        test_full_sweep();
        test_reset_midrun();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for a MIPS-style datapath.
- Two independent combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (supplies register indices) and writeback (supplies write data).

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, width of the register index ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Read1  input  ADDR_W  index for read port 1.
- Read2  input  ADDR_W  index for read port 2.
- WriteReg  input  ADDR_W  index for the write port.
- RegWrite  input  2  write enable; any nonzero value enables a write.
- WriteData  input  DATA_W  data to write.
- Data1  output  DATA_W  contents of register Read1.
- Data2  output  DATA_W  contents of register Read2.

Behaviour:
- Reset:
  - rst_n low immediately clears all NUM_REGS registers to 0, independent of clk.
  - Data1 and Data2 therefore read 0 during reset.
  - Deassertion takes effect at the next rising edge of clk.
- Write:
  - On rising clk edge with rst_n high and RegWrite != 2'b00: reg[WriteReg] <= WriteData.
  - RegWrite values 01, 10 and 11 behave identically.
  - RegWrite == 00 leaves all registers unchanged.
- Register 0:
  - Writes with WriteReg == 0 are discarded.
  - reg[0] always reads 0.
- Read:
  - Purely combinational: Data1 = reg[Read1], Data2 = reg[Read2], zero latency.
  - Both ports may address the same register, and either may address WriteReg.
- No write-to-read bypass:
  - A read of the register being written returns the old value until the clock edge.
  - The new value appears immediately after the edge (same delta cycle as the update).
- Reset asserted mid-write: reset wins and the write is lost.
- X/Z on an index is not supported.

Decomposition:
- Shared package rf_pkg holds:
  - DATA_W and ADDR_W constants;
  - typedefs reg_idx_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]);
  - constant ZERO_REG = 0.
- Optional sub-module rf_read_port: combinational index -> data mux with forced zero for index 0, instantiated twice.
- The storage array and write logic stay in register_file.

Test Plan:
- Reset: assert rst_n low mid-simulation after registers hold data -> Data1 and Data2 read 0 immediately for every index 0..31, with no clock edge required.
- Basic write/read: set WriteReg=1, WriteData=32'h55555555, RegWrite=1, Read1=1, then clock once -> Data1=32'h55555555 after the edge; Data2 (Read2=0) stays 0.
- Register 0 write: set WriteReg=0, WriteData=32'hFFFFFFFF, RegWrite=1, then clock -> Data1/Data2 with index 0 read 0.
- No bypass / overwrite: with reg1=32'h55555555, set Read2=1, WriteReg=1, WriteData=32'haaaaaaaa, RegWrite=1.
  - Before the edge: Data2=32'h55555555.
  - After the edge: Data2=32'haaaaaaaa.
- Write disable: set RegWrite=0, WriteReg=5, WriteData=32'h12345678, then clock -> reg5 still 0.
  - Repeat with RegWrite=2 -> reg5=32'h12345678.
- Full sweep: write reg[i]=32'hA5A50000+i for i=1..31, then read all pairs (i, 31-i) on both ports -> every value matches; reg0=0.
